// File: rtl/shift_out_reader_pkg.sv
// Shared types and constants for the shift_out_reader slice.
// Optional parity support is selected with SHIFT_OUT_PARITY_EN (see shift_out_reader.sv).
package shift_out_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_BIT_CYCLES = 1;

    // Enough bits to index n distinct values, never narrower than one bit.
    function automatic int counter_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_out_reader_if.sv
// Load handshake and serial output bundle between a word source and shift_out_reader.
interface shift_out_reader_if
    import shift_out_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             frame;
    logic             done;

    modport master (
        output load_data, load_valid,
        input  load_ready, serial_out, frame, done
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, serial_out, frame, done
    );
endinterface

// File: rtl/shift_out_reader_bit_timer.sv
// Bit-period down-counter: tick is high on the last clock of every BIT_CYCLES-long bit.
module bit_timer
    import shift_out_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int TW = counter_width(BIT_CYCLES + 1);
    localparam logic [TW-1:0] RELOAD = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] count;

    // Reloads on restart or after each tick, so consecutive bits need no extra control.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (restart || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - TW'(1);
        end
    end

    assign tick = (count == '0);
endmodule

// File: rtl/shift_out_reader.sv
// Accepts a parallel word over a valid/ready handshake and shifts it out serially with frame/done.
// Define SHIFT_OUT_PARITY_EN to append one even-parity bit after the data bits.
module shift_out_reader
    import shift_out_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MSB_FIRST  = 1,
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    shift_out_reader_if.slave  bus
);
    localparam int BW = counter_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic             tick;
    logic             restart;
    logic             accept;
    logic             last_bit;
    logic             head;
`ifdef SHIFT_OUT_PARITY_EN
    logic             parity_q;
`endif

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    assign accept   = (state == IDLE) && bus.load_valid;
    assign last_bit = (bitcnt == LAST_BIT);
    assign head     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        restart        = 1'b0;
        bus.load_ready = 1'b0;
        bus.frame      = 1'b0;
        bus.serial_out = 1'b0;
        bus.done       = 1'b0;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
                restart        = 1'b1;
                if (bus.load_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                bus.frame      = 1'b1;
                bus.serial_out = head;
                if (tick && last_bit) begin
`ifdef SHIFT_OUT_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
                    bus.done   = 1'b1;
`endif
                end
            end
`ifdef SHIFT_OUT_PARITY_EN
            PARITY: begin
                bus.frame      = 1'b1;
                bus.serial_out = parity_q;
                if (tick) begin
                    state_next = IDLE;
                    bus.done   = 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The word is captured only in IDLE, so load_data changes mid-frame cannot leak in.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg  <= '0;
            bitcnt <= '0;
`ifdef SHIFT_OUT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (accept) begin
            shreg  <= bus.load_data;
            bitcnt <= '0;
`ifdef SHIFT_OUT_PARITY_EN
            parity_q <= ^bus.load_data;
`endif
        end else if ((state == SHIFT) && tick) begin
            if (MSB_FIRST != 0) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            bitcnt <= last_bit ? '0 : bitcnt + BW'(1);
        end
    end
endmodule

// File: tb/tb_shift_out_reader.sv
// Self-checking bench for shift_out_reader: an MSB-first 1-clock/bit instance and an LSB-first 3-clock/bit instance.
module tb_shift_out_reader;

`ifdef SHIFT_OUT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] loadData [2];
    logic       loadValid [2];
    logic [1:0] serialOut;
    logic [1:0] frameOut;
    logic [1:0] readyOut;
    logic [1:0] doneOut;

    bit msbOf [2] = '{1'b1, 1'b0};
    int bcOf  [2] = '{1, 3};

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    shift_out_reader_if #(.WIDTH(8)) busA ();
    shift_out_reader_if #(.WIDTH(8)) busB ();

    assign busA.load_data  = loadData[0];
    assign busA.load_valid = loadValid[0];
    assign busB.load_data  = loadData[1];
    assign busB.load_valid = loadValid[1];
    assign serialOut[0] = busA.serial_out;
    assign frameOut[0]  = busA.frame;
    assign readyOut[0]  = busA.load_ready;
    assign doneOut[0]   = busA.done;
    assign serialOut[1] = busB.serial_out;
    assign frameOut[1]  = busB.frame;
    assign readyOut[1]  = busB.load_ready;
    assign doneOut[1]   = busB.done;

    shift_out_reader #(.WIDTH(8), .MSB_FIRST(1), .BIT_CYCLES(1)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    shift_out_reader #(.WIDTH(8), .MSB_FIRST(0), .BIT_CYCLES(3)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    // Reference: frame clock j carries data bit j/bc in send order, then the even-parity bit.
    function automatic logic expBit(input logic [7:0] w, input bit msb, input int bc, input int j);
        int b;
        b = j / bc;
        if (b >= 8) return ^w;
        return msb ? w[7-b] : w[b];
    endfunction

    task automatic tick1();
        @(posedge clock);
        #1;
    endtask

    // Compares {serial_out, frame, load_ready, done} of one instance.
    task automatic checkOutput(input int idx, input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {serialOut[idx], frameOut[idx], readyOut[idx], doneOut[idx]};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d {ser,frame,ready,done} got=%b expected=%b", name, idx, act, exp);
        end
    endtask

    // Loads one word in the current (IDLE) cycle and checks every frame clock plus the following IDLE cycle.
    task automatic applyStimulus(input int idx, input logic [7:0] word, input bit hold,
                                 input logic [7:0] alt, input string name);
        int n;
        n = (8 + PAR) * bcOf[idx];
        checkOutput(idx, {name, "_ready"}, 4'b0010);
        loadValid[idx] = 1'b1;
        loadData[idx]  = word;
        tick1();
        if (hold) loadData[idx] = alt;
        else      loadValid[idx] = 1'b0;
        for (int j = 0; j < n; j++) begin
            checkOutput(idx, $sformatf("%s_c%0d", name, j + 1),
                        {expBit(word, msbOf[idx], bcOf[idx], j), 1'b1, 1'b0, (j == n - 1)});
            tick1();
        end
        checkOutput(idx, {name, "_after"}, 4'b0010);
        loadValid[idx] = 1'b0;
    endtask

    typedef struct {
        logic [7:0] word;
        bit         hold;
        logic [7:0] alt;
        int         gap;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'h00, 0};
        vecs[1] = '{8'h81, 1'b0, 8'h00, 1};
        vecs[2] = '{8'h7E, 1'b0, 8'h00, 0};
        vecs[3] = '{8'h3C, 1'b1, 8'hFF, 2};
        vecs[4] = '{8'hFF, 1'b0, 8'h00, 0};
        vecs[5] = '{8'h07, 1'b0, 8'h00, 1};
        vecs[6] = '{8'h00, 1'b0, 8'h00, 0};
        vecs[7] = '{8'h5A, 1'b1, 8'hC3, 3};

        loadData[0] = 8'h00; loadData[1] = 8'h00;
        loadValid[0] = 1'b0; loadValid[1] = 1'b0;
        reset = 1'b1;
        tick1();
        tick1();
        checkOutput(0, "reset_state", 4'b0010);
        checkOutput(1, "reset_state", 4'b0010);
        reset = 1'b0;
        tick1();

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < vecs[i].gap; g++) begin
                checkOutput(0, $sformatf("gap_v%0d", i), 4'b0010);
                tick1();
            end
            applyStimulus(0, vecs[i].word, vecs[i].hold, vecs[i].alt, $sformatf("vecA%0d", i));
        end

        $display("[TB] LSB-first, 3 clocks per bit");
        applyStimulus(1, 8'h01, 1'b0, 8'h00, "b_01");
        applyStimulus(1, 8'hA5, 1'b1, 8'h5A, "b_A5");

        $display("[TB] reset mid-frame");
        loadValid[0] = 1'b1;
        loadData[0]  = 8'hA5;
        tick1();
        loadValid[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checkOutput(0, $sformatf("pre_reset_c%0d", j + 1), {expBit(8'hA5, 1'b1, 1, j), 3'b100});
            if (j < 3) tick1();
        end
        reset = 1'b1;
        tick1();
        checkOutput(0, "reset_abort", 4'b0010);
        checkOutput(1, "reset_abort", 4'b0010);
        reset = 1'b0;
        applyStimulus(0, 8'h0F, 1'b0, 8'h00, "after_reset_0F");

        $display("[TB] random words");
        for (int r = 0; r < 24; r++) begin
            int idx;
            int gap;
            logic [7:0] w;
            logic [7:0] junk;
            bit hold;
            idx  = int'($urandom_range(0, 1));
            gap  = int'($urandom_range(0, 2));
            w    = 8'($urandom);
            junk = 8'($urandom);
            hold = 1'($urandom);
            for (int g = 0; g < gap; g++) begin
                checkOutput(idx, $sformatf("rnd_gap%0d", r), 4'b0010);
                tick1();
            end
            applyStimulus(idx, w, hold, junk, $sformatf("rnd%0d", r));
        end

        tick1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
